// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shift types, widths and arbiter FSM states
package shift_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    localparam logic [2:0] SHL = 3'b000;
    localparam logic [2:0] SHR = 3'b001;
    localparam logic [2:0] ASL = 3'b010;
    localparam logic [2:0] ASR = 3'b011;
    localparam logic [2:0] ROL = 3'b100;
    localparam logic [2:0] ROR = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/shifting_top.sv
// rtl/shifting_top.sv - combinational 16-bit shifter/rotator, unused types give zero
module shifting_top
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    input  logic [2:0]        op_type,
    output logic [DATA_W-1:0] result
);

    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] dbl_left;
    logic [2*DATA_W-1:0] dbl_right;
    logic [DATA_W-1:0]   asr_res;

    // Rotates come from shifting the operand concatenated with itself.
    assign dbl       = {data, data};
    assign dbl_left  = dbl << amt;
    assign dbl_right = dbl >> amt;
    assign asr_res   = $unsigned($signed(data) >>> amt);

    always_comb begin
        result = '0;
        case (op_type)
            SHL:     result = data << amt;
            SHR:     result = data >> amt;
            ASL:     result = data << amt;
            ASR:     result = asr_res;
            ROL:     result = dbl_left[2*DATA_W-1:DATA_W];
            ROR:     result = dbl_right[DATA_W-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end for a shared shifter
module shift_arbiter
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic [2:0]        req0_type,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic [2:0]        req1_type,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              last_grant;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] op_data;
    logic [AMT_W-1:0]  op_amt;
    logic [2:0]        op_type;
    logic              op_idx;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] result_q;

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_data    <= '0;
            op_amt     <= '0;
            op_type    <= '0;
            op_idx     <= 1'b0;
            result_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant;
                op_idx     <= grant;
                op_data    <= grant ? req1_data : req0_data;
                op_amt     <= grant ? req1_amt  : req0_amt;
                op_type    <= grant ? req1_type : req0_type;
            end
            if (state == EXEC) begin
                result_q <= shift_res;
            end
        end
    end

    shifting_top u_shifter (
        .data    (op_data),
        .amt     (op_amt),
        .op_type (op_type),
        .result  (shift_res)
    );

    assign rsp0_valid = (state == RESP) && !op_idx;
    assign rsp1_valid = (state == RESP) && op_idx;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  req0_amt, req1_amt;
    logic [2:0]  req0_type, req1_type;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_data, rsp1_data;
    logic        busy;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_type  (req0_type),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_type  (req1_type),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated operation: drive in IDLE, then walk accept -> EXEC -> RESP -> IDLE.
    task automatic run_op(input string tag, input bit r, input logic [15:0] d,
                          input logic [3:0] a, input logic [2:0] t, input logic [15:0] exp);
        int busy_cycles;
        busy_cycles = 0;
        @(negedge clk);
        if (r) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_type = t;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_type = t;
        end
        #1;
        check({tag, " ready_own"},   r ? req1_ready : req0_ready, 1);
        check({tag, " ready_other"}, r ? req0_ready : req1_ready, 0);
        check({tag, " idle_busy"},   busy, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        busy_cycles += int'(busy);
        check({tag, " exec_ready"}, {req0_ready, req1_ready}, 0);
        check({tag, " exec_rsp"},   {rsp0_valid, rsp1_valid}, 0);
        @(negedge clk);
        #1;
        busy_cycles += int'(busy);
        check({tag, " rsp_valid"}, {rsp1_valid, rsp0_valid}, r ? 2'b10 : 2'b01);
        check({tag, " rsp_data"},  r ? rsp1_data : rsp0_data, exp);
        check({tag, " rsp_other_data"}, r ? rsp0_data : rsp1_data, exp);
        @(negedge clk);
        #1;
        busy_cycles += int'(busy);
        check({tag, " rsp_pulse_end"}, {rsp0_valid, rsp1_valid}, 0);
        check({tag, " busy_cycles"}, busy_cycles, 2);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h0001; req0_amt = 4'd1;  req0_type = 3'b000;
        req1_valid = 1'b1; req1_data = 16'h8000; req1_amt = 4'd15; req1_type = 3'b001;

        // Reset state with both requesters already asserting.
        repeat (2) @(negedge clk);
        #1;
        check("reset ready", {req0_ready, req1_ready}, 0);
        check("reset rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("reset rsp0_data", rsp0_data, 16'h0000);
        check("reset rsp1_data", rsp1_data, 16'h0000);
        check("reset busy", busy, 0);

        // Contention: grants 0,1,0,1, one op every 3 cycles.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int g;
            g = (k / 3) % 2;
            #1;
            if (k % 3 == 0) begin
                check($sformatf("cont ready k%0d", k), {req1_ready, req0_ready}, (g == 1) ? 2'b10 : 2'b01);
            end else if (k % 3 == 2) begin
                check($sformatf("cont rsp_valid k%0d", k), {rsp1_valid, rsp0_valid}, (g == 1) ? 2'b10 : 2'b01);
                check($sformatf("cont rsp_data k%0d", k), (g == 1) ? rsp1_data : rsp0_data,
                      (g == 1) ? 16'h0001 : 16'h0002);
            end else begin
                check($sformatf("cont busy k%0d", k), busy, 1);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("cont drained busy", busy, 0);

        run_op("shl",   1'b0, 16'h00F0, 4'd4,  3'b000, 16'h0F00);
        run_op("ror",   1'b1, 16'h1234, 4'd4,  3'b101, 16'h4123);
        run_op("rol",   1'b1, 16'h1234, 4'd4,  3'b100, 16'h2341);
        run_op("type7", 1'b0, 16'hFFFF, 4'd3,  3'b111, 16'h0000);
        run_op("rol0",  1'b1, 16'hA5A5, 4'd0,  3'b100, 16'hA5A5);
        run_op("asr",   1'b0, 16'h8010, 4'd4,  3'b011, 16'hF801);
        run_op("shr",   1'b1, 16'h8010, 4'd4,  3'b001, 16'h0801);
        run_op("asl",   1'b0, 16'h8421, 4'd1,  3'b010, 16'h0842);
        run_op("type6", 1'b1, 16'h1234, 4'd0,  3'b110, 16'h0000);
        run_op("shl15", 1'b0, 16'h0003, 4'd15, 3'b000, 16'h8000);

        // Reset during EXEC after a requester-0 grant; pointer must return to "last 1".
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 16'h0F0F; req0_amt = 4'd2; req0_type = 3'b000;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("midrst in_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        check("midrst rsp0_data", rsp0_data, 16'h0000);
        check("midrst rsp1_data", rsp1_data, 16'h0000);
        check("midrst ready", {req0_ready, req1_ready}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("midrst no_rsp k%0d", k), {rsp0_valid, rsp1_valid, busy}, 0);
            @(negedge clk);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("midrst tie_grant", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst tie_rsp", {rsp1_valid, rsp0_valid}, 2'b01);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL expose these ports:
  - clk        input   1   rising-edge clock
  - rst_n      input   1   reset, asynchronous assert, active-low
  - req0_valid input   1   requester 0 has an operation pending
  - req0_data  input   16  requester 0 operand
  - req0_amt   input   4   requester 0 shift amount, 0..15
  - req0_type  input   3   requester 0 shift type
  - req0_ready output  1   requester 0 operation accepted this cycle
  - req1_valid, req1_data, req1_amt, req1_type, req1_ready: same as requester 0, for requester 1
  - rsp0_valid output  1   one-cycle pulse, result for requester 0
  - rsp0_data  output  16  requester 0 result, meaningful when rsp0_valid is high
  - rsp1_valid, rsp1_data: same as requester 0, for requester 1
  - busy       output  1   an operation is in flight
REQ-002 The block SHALL use one clock, clk; rst_n SHALL be asynchronous and active-low.

Function
REQ-003 The FSM SHALL have three states, IDLE, EXEC and RESP; reset SHALL enter IDLE.
REQ-004 IDLE -> EXEC SHALL occur on any cycle in which at least one reqN_valid is high.
REQ-005 In that IDLE cycle, reqN_ready SHALL be high, combinationally, for the granted requester only.
REQ-006 The accept edge SHALL latch data, amt, type and the grant index.
REQ-007 When both requesters are valid, the grant SHALL go to the requester not granted last (round-robin); after reset, requester 0 SHALL win the first tie.
REQ-008 When exactly one requester is valid, that requester SHALL be granted; the round-robin pointer SHALL still update to the granted index.
REQ-009 EXEC SHALL apply the latched operands to the shifter; the shifter output SHALL be registered into a 16-bit result register; EXEC -> RESP unconditionally.
REQ-010 In RESP, rspN_valid SHALL be high for exactly one cycle for the latched grant index, with rspN_data equal to the result register; RESP -> IDLE unconditionally.
REQ-011 Latency SHALL be fixed: accept at edge T, rspN_valid high in cycle T+2. Peak throughput SHALL be one operation per 3 cycles.
REQ-012 The non-granted rspN_valid SHALL stay low; both rspN_data outputs SHALL hold the last result and change only on the EXEC edge.
REQ-013 reqN_ready SHALL be low in EXEC and RESP; requesters SHALL hold valid and operands stable until ready.
REQ-014 busy SHALL be high in EXEC and RESP and low in IDLE.
REQ-015 Shift types 3'b110 and 3'b111 SHALL be accepted and SHALL produce result 16'h0000 with a normal response.
REQ-016 amt = 0 SHALL return the operand unchanged for types 000 through 101.
REQ-017 A reqN_valid that falls before being granted SHALL be dropped with no response and no pointer change.

Reset
REQ-018 While rst_n is low: state = IDLE, req0_ready = req1_ready = 0, rsp0_valid = rsp1_valid = 0, rsp0_data = rsp1_data = 16'h0000, busy = 0, round-robin pointer = "last granted 1", latched operands = 0.
REQ-019 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no rspN_valid pulse, including after rst_n releases.

Structure
REQ-020 A shared package shift_pkg SHALL hold:
  - shift-type constants SHL=000, SHR=001, ASL=010, ASR=011, ROL=100, ROR=101;
  - the FSM state enum;
  - width constants DATA_W = 16 and AMT_W = 4.
REQ-021 The block SHALL instantiate exactly one existing shifting_top as its only sub-module; it SHALL be driven only from latched registers.

Verification
REQ-022 Single shift: req0 = {0x00F0, amt 4, SHL} -> req0_ready in the accept cycle, rsp0_valid two cycles later, rsp0_data = 0x0F00, rsp1_valid never high.
REQ-023 Rotate: req1 = {0x1234, amt 4, ROR} -> rsp1_data = 0x4123; the same operand with ROL amt 4 -> 0x2341.
REQ-024 Contention: both valid continuously from reset, req0 = {0x0001, 1, SHL}, req1 = {0x8000, 15, SHR} -> grant order 0,1,0,1; responses 0x0002 and 0x0001 alternate, spaced 3 cycles apart.
REQ-025 Unused type: req0 = {0xFFFF, 3, type 111} -> rsp0_data = 0x0000, rsp0_valid pulse width 1.
REQ-026 Reset mid-op: pull rst_n low in EXEC -> all outputs take reset values immediately, no response afterwards, next tie granted to requester 0.
REQ-027 Zero amount: req1 = {0xA5A5, 0, ROL} -> rsp1_data = 0xA5A5; busy is high for exactly 2 cycles per operation.
